// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: FSM state encoding, default frame/baud parameters,
// and tick-counter sizing used by both serial directions.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam int DBIT_DEF    = 8;
  localparam int SB_TICK_DEF = 16;
  localparam int DVSR_DEF    = 163;
  localparam int OS_TICKS    = 16;

  // Tick counter must also hold the stop length, which may exceed one bit time
  function automatic int tick_w(input int sb_tick);
    return $clog2((sb_tick > OS_TICKS) ? sb_tick : OS_TICKS);
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Oversampling tick generator: one-cycle s_tick every DVSR clk cycles.
// Latency: first tick DVSR cycles after clr drops; no backpressure, clr restarts the count.
module baud_tick_gen
  import uart_tx_pkg::*;
#(
  parameter int DVSR = DVSR_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic s_tick
);

  localparam int CW = (DVSR > 1) ? $clog2(DVSR) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DVSR - 1);

  logic [CW-1:0] cnt;

  assign s_tick = (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!reset || clr || s_tick) cnt <= '0;
    else                         cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: pops one FIFO word per frame and shifts it out LSB first.
// Latency: pop at edge k, start bit on tx from edge k+1; FIFO is only sampled while idle.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int DBIT       = DBIT_DEF,
  parameter int SB_TICK    = SB_TICK_DEF,
  parameter int DVSR       = DVSR_DEF,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fifo_empty,
  input  logic [DBIT-1:0] fifo_r_data,
  output logic            fifo_rd,
  output logic            tx,
  output logic            tx_busy,
  output logic            tx_done_tick
);

  localparam int SW = tick_w(SB_TICK);
  localparam int NW = $clog2(DBIT);
  localparam logic [SW-1:0] BIT_LAST  = SW'(OS_TICKS - 1);
  localparam logic [SW-1:0] STOP_LAST = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST    = NW'(DBIT - 1);
  localparam logic          HAS_PAR   = (PARITY_EN != 0);
  localparam logic          ODD       = (PARITY_ODD != 0);

  state_t            state, state_next;
  logic [SW-1:0]     s, s_next;
  logic [NW-1:0]     n, n_next;
  logic [DBIT-1:0]   shift, shift_next;
  logic              par, par_next;
  logic              tx_next;
  logic              done_next, done_pend;
  logic              baud_clr;
  logic              s_tick;

  // Held clear while idle so every frame starts on a fresh bit boundary
  assign baud_clr = (state == IDLE);
  assign tx_busy  = (state != IDLE);

  baud_tick_gen #(.DVSR(DVSR)) u_baud (
    .clk    (clk),
    .reset  (reset),
    .clr    (baud_clr),
    .s_tick (s_tick)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      s            <= '0;
      n            <= '0;
      shift        <= '0;
      par          <= 1'b0;
      tx           <= 1'b1;
      done_pend    <= 1'b0;
      tx_done_tick <= 1'b0;
    end else begin
      state        <= state_next;
      s            <= s_next;
      n            <= n_next;
      shift        <= shift_next;
      par          <= par_next;
      tx           <= tx_next;
      // Extra stage keeps the pulse aligned with the stop bit leaving the registered tx
      done_pend    <= done_next;
      tx_done_tick <= done_pend;
    end
  end

  always_comb begin
    state_next = state;
    s_next     = s;
    n_next     = n;
    shift_next = shift;
    par_next   = par;
    tx_next    = 1'b1;
    done_next  = 1'b0;
    fifo_rd    = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty && reset) begin
          fifo_rd    = 1'b1;
          shift_next = fifo_r_data;
          par_next   = (^fifo_r_data) ^ ODD;
          s_next     = '0;
          n_next     = '0;
          state_next = START;
        end
      end
      START: begin
        tx_next = 1'b0;
        if (s_tick) begin
          if (s == BIT_LAST) begin
            s_next     = '0;
            n_next     = '0;
            state_next = DATA;
          end else begin
            s_next = s + SW'(1);
          end
        end
      end
      DATA: begin
        tx_next = shift[0];
        if (s_tick) begin
          if (s == BIT_LAST) begin
            s_next     = '0;
            shift_next = shift >> 1;
            if (n == N_LAST) state_next = HAS_PAR ? PARITY : STOP;
            else             n_next     = n + NW'(1);
          end else begin
            s_next = s + SW'(1);
          end
        end
      end
      PARITY: begin
        tx_next = par;
        if (s_tick) begin
          if (s == BIT_LAST) begin
            s_next     = '0;
            state_next = STOP;
          end else begin
            s_next = s + SW'(1);
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s == STOP_LAST) begin
            s_next     = '0;
            done_next  = 1'b1;
            state_next = IDLE;
          end else begin
            s_next = s + SW'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four instances (plain, even parity, odd parity, two stop bits)
// fed from queue-backed FIFO models and checked against a frame model.
module tb_uart_tx;

  localparam int BIT_CLK = 32;

  logic       clk;
  logic       reset;
  logic       fe   [4];
  logic [7:0] fd   [4];
  logic       rd   [4];
  logic       tx   [4];
  logic       busy [4];
  logic       done [4];

  typedef logic [7:0] word_q_t[$];
  word_q_t fq [4];
  logic    tog     [4];
  int      pops    [4];
  int      pop_cyc [4];
  int      cyc;
  int      total;
  int      passed;

  int cfg_par [4] = '{0, 1, 1, 0};
  int cfg_odd [4] = '{0, 0, 1, 0};
  int cfg_sb  [4] = '{16, 16, 16, 32};

  typedef struct {
    int          dut;
    logic [7:0]  word;
    logic [11:0] bits;
    int          nb;
    int          stop_clk;
    bit          toggle;
  } vec_t;
  vec_t vecs [7];

  uart_tx #(.DBIT(8), .SB_TICK(16), .DVSR(2), .PARITY_EN(0), .PARITY_ODD(0)) u_dut0 (
    .clk(clk), .reset(reset), .fifo_empty(fe[0]), .fifo_r_data(fd[0]), .fifo_rd(rd[0]),
    .tx(tx[0]), .tx_busy(busy[0]), .tx_done_tick(done[0]));
  uart_tx #(.DBIT(8), .SB_TICK(16), .DVSR(2), .PARITY_EN(1), .PARITY_ODD(0)) u_dut1 (
    .clk(clk), .reset(reset), .fifo_empty(fe[1]), .fifo_r_data(fd[1]), .fifo_rd(rd[1]),
    .tx(tx[1]), .tx_busy(busy[1]), .tx_done_tick(done[1]));
  uart_tx #(.DBIT(8), .SB_TICK(16), .DVSR(2), .PARITY_EN(1), .PARITY_ODD(1)) u_dut2 (
    .clk(clk), .reset(reset), .fifo_empty(fe[2]), .fifo_r_data(fd[2]), .fifo_rd(rd[2]),
    .tx(tx[2]), .tx_busy(busy[2]), .tx_done_tick(done[2]));
  uart_tx #(.DBIT(8), .SB_TICK(32), .DVSR(2), .PARITY_EN(0), .PARITY_ODD(0)) u_dut3 (
    .clk(clk), .reset(reset), .fifo_empty(fe[3]), .fifo_r_data(fd[3]), .fifo_rd(rd[3]),
    .tx(tx[3]), .tx_busy(busy[3]), .tx_done_tick(done[3]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: time %0t exceeded budget", $time);
    $fatal(1, "watchdog expired");
  end

  // tog forces a non-empty flag with junk data to provoke stray pops
  function automatic void refresh();
    for (int i = 0; i < 4; i++) begin
      fe[i] = (fq[i].size() == 0) && !tog[i];
      fd[i] = (fq[i].size() > 0) ? fq[i][0] : 8'($urandom);
    end
  endfunction

  initial begin
    cyc = 0;
    for (int i = 0; i < 4; i++) begin
      pops[i]    = 0;
      pop_cyc[i] = 0;
    end
    forever begin
      @(posedge clk);
      cyc++;
      for (int i = 0; i < 4; i++) begin
        if (rd[i] === 1'b1) begin
          pops[i]++;
          pop_cyc[i] = cyc;
          if (fq[i].size() > 0) void'(fq[i].pop_front());
        end
      end
      #1;
      refresh();
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  task automatic push(input int d, input logic [7:0] w);
    fq[d].push_back(w);
    refresh();
  endtask

  // Frame model: start, data LSB first, optional parity over the data ones count, stop
  function automatic void model(input int d, input logic [7:0] w,
                                output logic [11:0] bits, output int nb, output int stop_clk);
    int ones;
    bits = '0;
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      bits[i+1] = w[i];
      ones += int'(w[i]);
    end
    nb = 9;
    if (cfg_par[d] != 0) begin
      bits[9] = ((ones % 2) == 1) ^ (cfg_odd[d] != 0);
      nb = 10;
    end
    stop_clk = cfg_sb[d] * 2;
  endfunction

  task automatic run_frame(input int d, input logic [11:0] bits, input int nb, input int stop_clk,
                           input int p0, input bit toggle, input string name, output int k);
    int guard, len, j, match, region, bad_rd, bad_busy, ndone;
    bit in_stop;
    guard = 0;
    while (pops[d] <= p0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk({name, "_pop"}, 32'(pops[d] - p0), 32'd1);
    k = pop_cyc[d];
    if (pops[d] <= p0) return;
    len = nb * BIT_CLK + stop_clk;
    match = 0; region = 0; bad_rd = 0; bad_busy = 0; ndone = 0;
    while (cyc < k + len + 1) begin
      @(negedge clk);
      j = cyc - k;
      if (j >= 1 && j <= len) begin
        in_stop = (j > nb * BIT_CLK);
        if (tx[d] === (in_stop ? 1'b1 : bits[(j-1)/BIT_CLK])) match++;
        if ((!in_stop && (j % BIT_CLK) == 0) || j == len) begin
          chk($sformatf("%s_bit%0d_cycles", name, region), 32'(match),
              32'(in_stop ? stop_clk : BIT_CLK));
          match = 0;
          region++;
        end
        if (done[d] === 1'b1) ndone++;
      end
      if (j >= 1 && j < len) begin
        if (rd[d] !== 1'b0) bad_rd++;
        if (busy[d] !== 1'b1) bad_busy++;
      end
      if (j == len) begin
        if (busy[d] !== 1'b0) bad_busy++;
        chk({name, "_pops_at_end"}, 32'(pops[d] - p0), 32'd1);
      end
      if (j == len + 1) chk({name, "_done_tick"}, 32'(done[d]), 32'd1);
      if (toggle) begin
        tog[d] = (j < len - 40) && ((j % 5) < 2);
        refresh();
      end
    end
    chk({name, "_no_midframe_rd"}, 32'(bad_rd), 32'd0);
    chk({name, "_busy"}, 32'(bad_busy), 32'd0);
    chk({name, "_no_early_done"}, 32'(ndone), 32'd0);
  endtask

  initial begin
    int hi, nbusy, nrd, ndn, k1, k2, p0, nb, stop_clk, bad;
    logic [11:0] bits;
    logic [7:0] words [3];

    // bits[0] is the start bit, then data LSB first, then parity when enabled
    vecs[0] = '{dut: 0, word: 8'hA5, bits: 12'h14A, nb: 9,  stop_clk: 32, toggle: 1'b0};
    vecs[1] = '{dut: 1, word: 8'h07, bits: 12'h20E, nb: 10, stop_clk: 32, toggle: 1'b0};
    vecs[2] = '{dut: 2, word: 8'h07, bits: 12'h00E, nb: 10, stop_clk: 32, toggle: 1'b0};
    vecs[3] = '{dut: 1, word: 8'h00, bits: 12'h000, nb: 10, stop_clk: 32, toggle: 1'b0};
    vecs[4] = '{dut: 2, word: 8'h00, bits: 12'h200, nb: 10, stop_clk: 32, toggle: 1'b0};
    vecs[5] = '{dut: 3, word: 8'h5A, bits: 12'h0B4, nb: 9,  stop_clk: 64, toggle: 1'b1};
    vecs[6] = '{dut: 0, word: 8'h80, bits: 12'h100, nb: 9,  stop_clk: 32, toggle: 1'b0};

    total = 0;
    passed = 0;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) tog[i] = 1'b1;
    refresh();

    hi = 0; nbusy = 0; nrd = 0; ndn = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (tx[i] === 1'b1) hi++;
        if (busy[i] !== 1'b0) nbusy++;
        if (rd[i] !== 1'b0) nrd++;
        if (done[i] !== 1'b0) ndn++;
      end
    end
    chk("reset_tx_high", 32'(hi), 32'd20);
    chk("reset_busy_low", 32'(nbusy), 32'd0);
    chk("reset_rd_low", 32'(nrd), 32'd0);
    chk("reset_done_low", 32'(ndn), 32'd0);
    chk("reset_no_pops", 32'(pops[0] + pops[1] + pops[2] + pops[3]), 32'd0);
    for (int i = 0; i < 4; i++) tog[i] = 1'b0;
    refresh();
    reset = 1'b1;
    @(negedge clk);

    for (int r = 0; r < 7; r++) begin
      p0 = pops[vecs[r].dut];
      push(vecs[r].dut, vecs[r].word);
      run_frame(vecs[r].dut, vecs[r].bits, vecs[r].nb, vecs[r].stop_clk, p0, vecs[r].toggle,
                $sformatf("vec%0d", r), k1);
      repeat (3) @(negedge clk);
    end

    // Back-to-back 0x00 then 0xFF: one idle-high clk between frames
    p0 = pops[0];
    push(0, 8'h00);
    push(0, 8'hFF);
    run_frame(0, 12'h000, 9, 32, p0, 1'b0, "b2b_first", k1);
    chk("b2b_second_pop_cycle", 32'(pop_cyc[0] - k1), 32'd321);
    chk("b2b_idle_clk_high", 32'(tx[0]), 32'd1);
    run_frame(0, 12'h1FE, 9, 32, p0 + 1, 1'b0, "b2b_second", k2);
    repeat (3) @(negedge clk);

    // Reset pulse during data bit 4 of 0x3C abandons the frame
    p0 = pops[0];
    push(0, 8'h3C);
    bad = 0;
    while (pops[0] <= p0 && bad < 200) begin
      @(negedge clk);
      bad++;
    end
    chk("abort_pop", 32'(pops[0] - p0), 32'd1);
    k1 = pop_cyc[0];
    while (cyc < k1 + 5 * BIT_CLK + 10 && bad < 1000) begin
      @(negedge clk);
      bad++;
    end
    reset = 1'b0;
    @(negedge clk);
    chk("abort_tx_high", 32'(tx[0]), 32'd1);
    chk("abort_busy_low", 32'(busy[0]), 32'd0);
    reset = 1'b1;
    ndn = 0; hi = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (done[0] !== 1'b0) ndn++;
      if (tx[0] === 1'b1) hi++;
    end
    chk("abort_no_done", 32'(ndn), 32'd0);
    chk("abort_line_idle", 32'(hi), 32'd400);
    chk("abort_no_extra_pop", 32'(pops[0] - p0), 32'd1);
    model(0, 8'hC3, bits, nb, stop_clk);
    push(0, 8'hC3);
    run_frame(0, bits, nb, stop_clk, p0 + 1, 1'b0, "after_abort", k2);

    // Random words per instance, queued together so frames run back to back
    for (int d = 0; d < 4; d++) begin
      p0 = pops[d];
      for (int i = 0; i < 3; i++) begin
        words[i] = 8'($urandom);
        push(d, words[i]);
      end
      for (int i = 0; i < 3; i++) begin
        model(d, words[i], bits, nb, stop_clk);
        run_frame(d, bits, nb, stop_clk, p0 + i, 1'b0, $sformatf("rnd_d%0d_w%0d", d, i), k1);
      end
      repeat (3) @(negedge clk);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
